sort_seq_ctrl: RTL and testbench

SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

---
 rtl/sort_seq_ctrl_if.sv | 26 ++
 rtl/sort_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sort_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_seq_ctrl_if.sv
// Score-input and ranked-result handshakes between sort_seq_ctrl and its environment.
// slave is the controller's view, master is the producer/consumer's view.
interface sort_seq_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [5:0]            out_id;
  logic [3:0]            out_rank;
  logic                  out_last;

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_id, out_rank, out_last
  );

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_id, out_rank, out_last
  );
endinterface

// File: rtl/sort_seq_ctrl.sv
// Sequencer around an external top-10 sorter: load scores, clear, sort, drain ranked results.
// Optional SORT-state watchdog is enabled by defining SORT_SEQ_WATCHDOG_EN.
module sort_seq_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_WORDS    = 16,
  parameter int TOPK         = 10,
  parameter int SORT_TIMEOUT = 1023
) (
  input  logic                             clk,
  input  logic                             rst_n,
  sort_seq_ctrl_if.slave                   bus,
  output logic                             sort_rst,
  output logic                             sort_en,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  sort_array,
  input  logic                             sort_done,
  input  logic [DATA_WIDTH*TOPK-1:0]       sort_vals,
  input  logic [6*TOPK-1:0]                sort_ids,
  output logic                             busy,
  output logic                             timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    SORT,
    DRAIN
  } state_t;

  localparam logic [5:0] LAST_IDX  = 6'(NUM_WORDS - 1);
  localparam logic [3:0] LAST_RANK = 4'(TOPK - 1);

  // Elaboration-time guard on the supported parameter range.
  if (NUM_WORDS < 2 || NUM_WORDS > 63 || TOPK != 10 || SORT_TIMEOUT < 1) begin : g_param_check
    $error("sort_seq_ctrl: unsupported parameter set");
  end

  state_t                state;
  logic [5:0]            load_cnt;
  logic [3:0]            rank;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] words    [NUM_WORDS];
  logic [DATA_WIDTH-1:0] cap_vals [TOPK];
  logic [5:0]            cap_ids  [TOPK];
  logic                  beat_in;
  logic                  beat_out;

  assign beat_in  = (state == LOAD) && in_ready_r && bus.in_valid;
  assign beat_out = (state == DRAIN) && out_valid_r && bus.out_ready;

`ifdef SORT_SEQ_WATCHDOG_EN
  localparam int TMO_W = $clog2(SORT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_CNT = TMO_W'(SORT_TIMEOUT);

  logic [TMO_W-1:0] wd_cnt;
  logic             tmo_r;

  assign timeout_err = tmo_r;
`else
  assign timeout_err = 1'b0;
`endif

  // Control FSM; every handshake/status output is registered from the next-state decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      load_cnt    <= '0;
      rank        <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      sort_rst    <= 1'b1;
      sort_en     <= 1'b0;
      busy        <= 1'b0;
`ifdef SORT_SEQ_WATCHDOG_EN
      wd_cnt      <= '0;
      tmo_r       <= 1'b0;
`endif
    end else begin
      sort_rst <= 1'b0;
`ifdef SORT_SEQ_WATCHDOG_EN
      tmo_r    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= LOAD;
            load_cnt   <= '0;
            in_ready_r <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (beat_in) begin
            load_cnt <= load_cnt + 6'd1;
            if (load_cnt == LAST_IDX) begin
              state      <= CLEAR;
              in_ready_r <= 1'b0;
              sort_rst   <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state   <= SORT;
          sort_en <= 1'b1;
`ifdef SORT_SEQ_WATCHDOG_EN
          wd_cnt  <= '0;
`endif
        end
        SORT: begin
          if (sort_done) begin
            state       <= DRAIN;
            sort_en     <= 1'b0;
            out_valid_r <= 1'b1;
            rank        <= '0;
          end
`ifdef SORT_SEQ_WATCHDOG_EN
          else if (wd_cnt == TMO_CNT) begin
            state   <= IDLE;
            sort_en <= 1'b0;
            busy    <= 1'b0;
            tmo_r   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (beat_out) begin
            if (rank == LAST_RANK) begin
              state       <= IDLE;
              out_valid_r <= 1'b0;
              rank        <= '0;
              busy        <= 1'b0;
            end else begin
              rank <= rank + 4'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          sort_en     <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Score buffer and result capture; the buffer is only written in LOAD, so it is
  // frozen for the whole CLEAR/SORT/DRAIN window the sorter and drain rely on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_WORDS; j++) begin
        words[j] <= '0;
      end
      for (int r = 0; r < TOPK; r++) begin
        cap_vals[r] <= '0;
        cap_ids[r]  <= '0;
      end
    end else begin
      if (beat_in) begin
        for (int j = 0; j < NUM_WORDS; j++) begin
          if (load_cnt == 6'(j)) begin
            words[j] <= bus.in_data;
          end
        end
      end
      if ((state == SORT) && sort_done) begin
        for (int r = 0; r < TOPK; r++) begin
          cap_vals[r] <= sort_vals[r*DATA_WIDTH +: DATA_WIDTH];
          cap_ids[r]  <= sort_ids[r*6 +: 6];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
    assign sort_array[g*DATA_WIDTH +: DATA_WIDTH] = words[g];
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = cap_vals[rank];
  assign bus.out_id    = cap_ids[rank];
  assign bus.out_rank  = rank;
  assign bus.out_last  = out_valid_r && (rank == LAST_RANK);

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Directed bench for sort_seq_ctrl with a behavioural top-10 sorter stub.
// Define SORT_SEQ_WATCHDOG_EN to also exercise the SORT watchdog.
module tb_sort_seq_ctrl;

  localparam int DW  = 16;
  localparam int NW  = 16;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           sort_rst, sort_en, sort_done, busy, timeout_err;
  logic [DW*NW-1:0] sort_array;
  logic [DW*10-1:0] sort_vals;
  logic [59:0]      sort_ids;

  sort_seq_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  sort_seq_ctrl #(
    .DATA_WIDTH(DW), .NUM_WORDS(NW), .TOPK(10), .SORT_TIMEOUT(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sort_rst(sort_rst), .sort_en(sort_en), .sort_array(sort_array),
    .sort_done(sort_done), .sort_vals(sort_vals), .sort_ids(sort_ids),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Sorter stub: done after LAT enabled cycles, results only valid while done.
  int   en_cnt = 0;
  logic hold_done_low = 1'b0;
  logic [DW*10-1:0] vals_m;
  logic [59:0]      ids_m;

  always @(posedge clk) begin
    if (sort_rst) en_cnt <= 0;
    else if (sort_en) en_cnt <= en_cnt + 1;
  end

  always_comb begin
    logic [NW-1:0] used;
    logic [DW-1:0] bestv;
    int best;
    used = '0; bestv = '0; best = 0;
    vals_m = '0; ids_m = '0;
    for (int r = 0; r < 10; r++) begin
      best = -1; bestv = '0;
      for (int j = 0; j < NW; j++) begin
        if (!used[j] && (best < 0 || sort_array[j*DW +: DW] > bestv)) begin
          best = j; bestv = sort_array[j*DW +: DW];
        end
      end
      used[best] = 1'b1;
      vals_m[r*DW +: DW] = bestv;
      ids_m[r*6 +: 6]    = 6'(best);
    end
  end

  assign sort_done = sort_en && (en_cnt >= LAT) && !hold_done_low;
  assign sort_vals = sort_done ? vals_m : {10{16'hDEAD}};
  assign sort_ids  = sort_done ? ids_m  : {10{6'h2A}};

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] stim  [NW];
  logic [DW-1:0] exp_v [10];
  logic [5:0]    exp_i [10];
  logic [DW-1:0] got_v [10];
  logic [5:0]    got_i [10];
  logic [3:0]    got_r [10];
  logic          got_l [10];
  int            got_n;

  // Drives start (unless already in LOAD) and NW input beats; returns at the CLEAR-cycle negedge.
  task automatic load_job(input bit skip_start, input bit poke_start);
    if (!skip_start) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int i = 0; i < NW; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      bus.start    = poke_start && (i == 5);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic collect();
    got_n = 0;
    for (int cyc = 0; cyc < 300 && got_n < 10; cyc++) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        got_v[got_n] = bus.out_data; got_i[got_n] = bus.out_id;
        got_r[got_n] = bus.out_rank; got_l[got_n] = bus.out_last;
        got_n++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({bus.in_ready, sort_rst, sort_en, bus.out_valid} !== 4'b0100) begin
      n_fail++; $display("FAIL rst_ctrl got ir/srst/sen/ov=%b exp=0100", {bus.in_ready, sort_rst, sort_en, bus.out_valid}); end
    n_checks++; if ({bus.out_last, bus.out_rank, busy, timeout_err} !== 7'b0) begin
      n_fail++; $display("FAIL rst_status got last/rank/busy/tmo=%b exp=0", {bus.out_last, bus.out_rank, busy, timeout_err}); end
    n_checks++; if (sort_array !== '0) begin
      n_fail++; $display("FAIL rst_array got=%h exp=0", sort_array); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (sort_rst !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_release got srst=%b busy=%b exp 0 0", sort_rst, busy); end
  endtask

  task automatic test_basic();
    logic [DW*NW-1:0] exp_arr;
    int lat;
    for (int i = 0; i < NW; i++) stim[i] = 16'(i);
    for (int i = 0; i < NW; i++) exp_arr[i*DW +: DW] = 16'(i);
    bus.in_valid = 1'b1; bus.in_data = 16'hFFFF;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_in_ready got ir=%b busy=%b exp 0 0", bus.in_ready, busy); end
    bus.in_valid = 1'b0;
    load_job(1'b0, 1'b1);
    n_checks++; if ({sort_rst, sort_en, bus.in_ready, busy} !== 4'b1001) begin
      n_fail++; $display("FAIL clear_state got srst/sen/ir/busy=%b exp=1001", {sort_rst, sort_en, bus.in_ready, busy}); end
    n_checks++; if (sort_array !== exp_arr) begin
      n_fail++; $display("FAIL load_array got=%h exp=%h", sort_array, exp_arr); end
    wait_valid(lat);
    n_checks++; if (lat !== 1 + 1 + LAT) begin
      n_fail++; $display("FAIL latency got=%0d exp=%0d", lat, 2 + LAT); end
    n_checks++; if (sort_en !== 1'b0 || sort_array !== exp_arr) begin
      n_fail++; $display("FAIL drain_entry got sen=%b arr=%h exp sen=0 arr=%h", sort_en, sort_array, exp_arr); end
    collect();
    n_checks++; if (got_n !== 10) begin
      n_fail++; $display("FAIL basic_count got=%0d exp=10", got_n); end
    for (int r = 0; r < got_n; r++) begin
      n_checks++;
      if ({got_v[r], got_i[r], got_r[r], got_l[r]} !== {16'(15 - r), 6'(15 - r), 4'(r), (r == 9)}) begin
        n_fail++; $display("FAIL basic_beat%0d got d=%0d id=%0d rk=%0d last=%b exp d=%0d id=%0d rk=%0d last=%b",
          r, got_v[r], got_i[r], got_r[r], got_l[r], 15 - r, 15 - r, r, (r == 9)); end
    end
    n_checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle got ov=%b busy=%b exp 0 0", bus.out_valid, busy); end
  endtask

  task automatic test_ties();
    logic [15:0] seen;
    int lat;
    logic ok;
    for (int i = 0; i < NW; i++) stim[i] = 16'd100;
    load_job(1'b0, 1'b0);
    wait_valid(lat);
    collect();
    n_checks++; if (got_n !== 10) begin
      n_fail++; $display("FAIL ties_count got=%0d exp=10", got_n); end
    seen = '0; ok = 1'b1;
    for (int r = 0; r < got_n; r++) begin
      if (got_v[r] !== 16'd100 || got_i[r] > 6'd15 || seen[got_i[r][3:0]]) ok = 1'b0;
      else seen[got_i[r][3:0]] = 1'b1;
    end
    n_checks++; if (ok !== 1'b1) begin
      n_fail++; $display("FAIL ties_unique got ids_seen=%h ok=%b exp all data 100 and distinct ids", seen, ok); end
  endtask

  task automatic test_backpressure();
    logic       pat [4];
    logic       prev_stall;
    logic [DW-1:0] pv; logic [5:0] pi; logic [3:0] pr;
    int lat, stall_bad;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < NW; i++) stim[i] = 16'((15 - i) * 10);
    load_job(1'b0, 1'b0);
    wait_valid(lat);
    got_n = 0; prev_stall = 1'b0; stall_bad = 0; pv = '0; pi = '0; pr = '0;
    for (int cyc = 0; cyc < 300 && got_n < 10; cyc++) begin
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== pv || bus.out_id !== pi || bus.out_rank !== pr))
        stall_bad++;
      bus.out_ready = pat[cyc % 4];
      prev_stall = bus.out_valid && !bus.out_ready;
      pv = bus.out_data; pi = bus.out_id; pr = bus.out_rank;
      if (bus.out_valid && bus.out_ready) begin
        got_v[got_n] = bus.out_data; got_i[got_n] = bus.out_id;
        got_r[got_n] = bus.out_rank; got_l[got_n] = bus.out_last;
        got_n++;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++; if (stall_bad !== 0) begin
      n_fail++; $display("FAIL bp_stable got unstable_stalls=%0d exp=0", stall_bad); end
    n_checks++; if (got_n !== 10) begin
      n_fail++; $display("FAIL bp_count got=%0d exp=10", got_n); end
    for (int r = 0; r < got_n; r++) begin
      n_checks++;
      if ({got_v[r], got_i[r], got_r[r], got_l[r]} !== {16'((15 - r) * 10), 6'(r), 4'(r), (r == 9)}) begin
        n_fail++; $display("FAIL bp_beat%0d got d=%0d id=%0d rk=%0d last=%b exp d=%0d id=%0d rk=%0d",
          r, got_v[r], got_i[r], got_r[r], got_l[r], (15 - r) * 10, r, r); end
    end
    repeat (3) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_extra got ov=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_midjob();
    int lat, spurious;
    for (int i = 0; i < NW; i++) stim[i] = 16'(i);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.in_data = stim[i];
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, bus.in_ready, bus.out_valid, sort_rst} !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_async got busy/ir/ov/srst=%b exp=0001", {busy, bus.in_ready, bus.out_valid, sort_rst}); end
    n_checks++; if (sort_array !== '0) begin
      n_fail++; $display("FAIL midrst_array got=%h exp=0", sort_array); end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    bus.in_valid = 1'b0;
    n_checks++; if (spurious !== 0) begin
      n_fail++; $display("FAIL midrst_quiet got active_cycles=%0d exp=0", spurious); end
    stim = '{16'd5, 16'd300, 16'd12, 16'd7, 16'd900, 16'd44, 16'd1, 16'd65535,
             16'd3, 16'd18, 16'd250, 16'd2, 16'd77, 16'd600, 16'd9, 16'd31};
    exp_v = '{16'd65535, 16'd900, 16'd600, 16'd300, 16'd250, 16'd77, 16'd44, 16'd31, 16'd18, 16'd12};
    exp_i = '{6'd7, 6'd4, 6'd13, 6'd1, 6'd10, 6'd12, 6'd5, 6'd15, 6'd9, 6'd2};
    load_job(1'b0, 1'b0);
    wait_valid(lat);
    collect();
    n_checks++; if (got_n !== 10) begin
      n_fail++; $display("FAIL fresh_count got=%0d exp=10", got_n); end
    for (int r = 0; r < got_n; r++) begin
      n_checks++;
      if ({got_v[r], got_i[r], got_r[r]} !== {exp_v[r], exp_i[r], 4'(r)}) begin
        n_fail++; $display("FAIL fresh_beat%0d got d=%0d id=%0d rk=%0d exp d=%0d id=%0d rk=%0d",
          r, got_v[r], got_i[r], got_r[r], exp_v[r], exp_i[r], r); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < NW; i++) stim[i] = 16'(i);
    load_job(1'b0, 1'b0);
    wait_valid(lat);
    for (int cyc = 0; cyc < 50; cyc++) begin
      bus.out_ready = 1'b1;
      if (bus.out_valid && bus.out_rank == 4'd9) begin
        bus.start = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_exit got busy=%b ir=%b exp 0 0", busy, bus.in_ready); end
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept got busy=%b ir=%b exp 1 1", busy, bus.in_ready); end
    load_job(1'b1, 1'b0);
    wait_valid(lat);
    collect();
    n_checks++;
    if (got_n !== 10 || got_v[0] !== 16'd15 || got_v[9] !== 16'd6 || got_l[9] !== 1'b1 || got_l[8] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_job got n=%0d d0=%0d d9=%0d l8=%b l9=%b exp 10 15 6 0 1",
        got_n, got_v[0], got_v[9], got_l[8], got_l[9]); end
  endtask

`ifdef SORT_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    int k;
    logic saw_valid;
    for (int i = 0; i < NW; i++) stim[i] = 16'(i);
    hold_done_low = 1'b1;
    load_job(1'b0, 1'b0);
    @(negedge clk);
    k = 0; saw_valid = 1'b0;
    while (!timeout_err && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    n_checks++; if (k !== 51) begin
      n_fail++; $display("FAIL wd_delay got=%0d exp=51", k); end
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL wd_idle got busy=%b exp=0", busy); end
    @(negedge clk);
    n_checks++; if (timeout_err !== 1'b0 || saw_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL wd_pulse got tmo=%b saw_ov=%b exp 0 0", timeout_err, saw_valid); end
    hold_done_low = 1'b0;
  endtask
`endif

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_reset_midjob();
    test_back_to_back();
`ifdef SORT_SEQ_WATCHDOG_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
